// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between NUM_REQ requesters.
// Latches the winner's operands, holds the divider handshake, returns a one-cycle response.
module div_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DIVIDEND_WIDTH-1:0]           resp_quotient,
    output logic [DIVISOR_WIDTH-1:0]            resp_remainder,
    output logic                                resp_overflow,
    output logic                                resp_timeout,
    output logic                                div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]            div_remainder,
    input  logic                                div_overflow,
    input  logic                                div_valid_out,
    output logic                                busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW:0]   NUM_REQ_W    = (GW + 1)'(NUM_REQ);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [GW-1:0]             last_grant_reg;
    logic [GW-1:0]             grant_reg;
    logic [GW-1:0]             grant_sel;
    logic                      grant_found;
    logic [GW:0]               rr_sum;
    logic [NUM_REQ-1:0]        grant_onehot;
    logic [CW-1:0]             count_reg;

    logic                      div_valid_in_reg;
    logic [DIVIDEND_WIDTH-1:0] div_dividend_reg;
    logic [DIVISOR_WIDTH-1:0]  div_divisor_reg;
    logic [NUM_REQ-1:0]        resp_valid_reg;
    logic [DIVIDEND_WIDTH-1:0] resp_quotient_reg;
    logic [DIVISOR_WIDTH-1:0]  resp_remainder_reg;
    logic                      resp_overflow_reg;
    logic                      resp_timeout_reg;

    logic [DIVIDEND_WIDTH-1:0] dividend_slice [NUM_REQ];
    logic [DIVISOR_WIDTH-1:0]  divisor_slice  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign dividend_slice[gi] = req_dividend[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
            assign divisor_slice[gi]  = req_divisor[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
        end
    endgenerate

    // Search starts one past the last winner and wraps, so the previous winner ranks last.
    always_comb begin
        grant_sel   = '0;
        grant_found = 1'b0;
        rr_sum      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, last_grant_reg} + (GW + 1)'(k);
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            if (!grant_found && req_valid[rr_sum[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_sel   = rr_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && (state_reg == IDLE) && grant_found) begin
            req_ready[grant_sel] = 1'b1;
        end
    end

    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_reg] = 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (div_valid_out || (count_reg == TIMEOUT_LAST)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            last_grant_reg     <= GW'(NUM_REQ - 1);
            grant_reg          <= '0;
            count_reg          <= '0;
            div_valid_in_reg   <= 1'b0;
            div_dividend_reg   <= '0;
            div_divisor_reg    <= '0;
            resp_valid_reg     <= '0;
            resp_quotient_reg  <= '0;
            resp_remainder_reg <= '0;
            resp_overflow_reg  <= 1'b0;
            resp_timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        grant_reg        <= grant_sel;
                        div_dividend_reg <= dividend_slice[grant_sel];
                        div_divisor_reg  <= divisor_slice[grant_sel];
                        count_reg        <= '0;
                        div_valid_in_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    // A completion in the watchdog's final cycle still counts as a real result.
                    if (div_valid_out) begin
                        resp_quotient_reg  <= div_quotient;
                        resp_remainder_reg <= div_remainder;
                        resp_overflow_reg  <= div_overflow;
                        resp_timeout_reg   <= 1'b0;
                        resp_valid_reg     <= grant_onehot;
                        div_valid_in_reg   <= 1'b0;
                    end else if (count_reg == TIMEOUT_LAST) begin
                        resp_quotient_reg  <= '0;
                        resp_remainder_reg <= '0;
                        resp_overflow_reg  <= 1'b0;
                        resp_timeout_reg   <= 1'b1;
                        resp_valid_reg     <= grant_onehot;
                        div_valid_in_reg   <= 1'b0;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                RESP: begin
                    resp_valid_reg <= '0;
                    last_grant_reg <= grant_reg;
                end
                default: begin
                    resp_valid_reg <= '0;
                end
            endcase
        end
    end

    assign busy           = (state_reg != IDLE);
    assign div_valid_in   = div_valid_in_reg;
    assign div_dividend   = div_dividend_reg;
    assign div_divisor    = div_divisor_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_quotient  = resp_quotient_reg;
    assign resp_remainder = resp_remainder_reg;
    assign resp_overflow  = resp_overflow_reg;
    assign resp_timeout   = resp_timeout_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider stub, round-robin scoreboard, table vectors and random traffic.
module tb_div_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, resp_valid;
    logic [NR*W-1:0]   req_dividend, req_divisor;
    logic [W-1:0]      resp_quotient, resp_remainder;
    logic              resp_overflow, resp_timeout;
    logic              div_valid_in;
    logic [W-1:0]      div_dividend, div_divisor, div_quotient, div_remainder;
    logic              div_overflow, div_valid_out;
    logic              busy;

    always #5 clk = ~clk;

    div_arbiter #(
        .NUM_REQ(NR), .DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_overflow(resp_overflow),
        .resp_timeout(resp_timeout),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_overflow(div_overflow), .div_valid_out(div_valid_out),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Divider stub: fixed latency, zero divisor gives all-ones quotient and overflow; hang never answers.
    int   lat_cfg = 3;
    bit   hang = 1'b0;
    logic dv_busy, dv_need_low;
    int   dv_cnt;
    logic [W-1:0] dv_a, dv_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_busy <= 1'b0; dv_need_low <= 1'b0; dv_cnt <= 0;
            dv_a <= '0; dv_b <= '0;
            div_valid_out <= 1'b0; div_quotient <= '0; div_remainder <= '0; div_overflow <= 1'b0;
        end else begin
            div_valid_out <= 1'b0;
            if (!div_valid_in) dv_need_low <= 1'b0;
            if (!dv_busy) begin
                if (div_valid_in && !dv_need_low) begin
                    dv_busy <= 1'b1; dv_cnt <= lat_cfg; dv_a <= div_dividend; dv_b <= div_divisor;
                end
            end else if (!div_valid_in) begin
                dv_busy <= 1'b0;
            end else if (dv_cnt > 1) begin
                dv_cnt <= dv_cnt - 1;
            end else if (!hang) begin
                div_valid_out <= 1'b1; dv_busy <= 1'b0; dv_need_low <= 1'b1;
                if (dv_b == 0) begin
                    div_quotient <= '1; div_remainder <= dv_a; div_overflow <= 1'b1;
                end else begin
                    div_quotient <= dv_a / dv_b; div_remainder <= dv_a % dv_b; div_overflow <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        int         idx;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       ovf;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   resp_log[$];
    logic [W-1:0] rq_log[$];
    logic [W-1:0] rr_log[$];
    int   model_last = NR - 1;
    logic [NR-1:0] acc_mask = '0;
    logic [NR-1:0] sticky = '0;
    logic [W-1:0] last_q, last_r;
    logic last_ovf, last_to;
    int   cyc = 0, vin_rise_cyc = 0, resp_cyc = 0, vin_windows = 0, resp_count = 0;
    logic vin_prev = 1'b0;

    // Reference model: round-robin from the last served index, one division in flight at a time.
    initial begin
        logic [NR-1:0] er;
        int gidx;
        exp_t e;
        logic [W-1:0] a, b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                exp_q.delete();
                model_last = NR - 1;
                vin_prev = 1'b0;
                continue;
            end
            chk("busy", busy, exp_q.size() != 0);
            er = '0;
            gidx = -1;
            if (exp_q.size() == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int i;
                    i = (model_last + k) % NR;
                    if (req_valid[i]) begin
                        er[i] = 1'b1;
                        gidx = i;
                        break;
                    end
                end
            end
            chk("req_ready", req_ready, er);
            if (gidx >= 0) begin
                acc_mask |= er;
                a = req_dividend[gidx*W +: W];
                b = req_divisor[gidx*W +: W];
                e.idx = gidx;
                if (hang) begin
                    e.q = '0; e.r = '0; e.ovf = 1'b0; e.to = 1'b1;
                end else if (b == 0) begin
                    e.q = '1; e.r = a; e.ovf = 1'b1; e.to = 1'b0;
                end else begin
                    e.q = a / b; e.r = a % b; e.ovf = 1'b0; e.to = 1'b0;
                end
                exp_q.push_back(e);
                grant_log.push_back(gidx);
            end
            if (div_valid_in && !vin_prev) begin
                vin_windows++;
                vin_rise_cyc = cyc;
            end
            vin_prev = div_valid_in;
            if (resp_valid != 0) begin
                resp_cyc = cyc;
                resp_count++;
                last_q = resp_quotient; last_r = resp_remainder;
                last_ovf = resp_overflow; last_to = resp_timeout;
                rq_log.push_back(resp_quotient);
                rr_log.push_back(resp_remainder);
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_valid", resp_valid, 64'd1 << e.idx);
                    chk("resp_quotient", resp_quotient, e.q);
                    chk("resp_remainder", resp_remainder, e.r);
                    chk("resp_overflow", resp_overflow, e.ovf);
                    chk("resp_timeout", resp_timeout, e.to);
                    model_last = e.idx;
                    resp_log.push_back(e.idx);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc_mask & ~sticky);
        acc_mask = '0;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((req_valid != 0 || busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_bound("wait_idle");
    endtask

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       ovf;
    } vec_t;

    initial begin
        vec_t vt[5];
        int g0, w0, base, n, r0, tot_g, tot_r;
        logic [NR-1:0] mask;
        logic [W-1:0] ra, rb;
        int q4[4];
        int r4[4];

        vt[0] = '{0, 32'd256, 32'd4, 32'd64, 32'd0, 1'b0};
        vt[1] = '{2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vt[2] = '{1, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0};
        vt[3] = '{0, 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0};
        vt[4] = '{3, 32'd1000, 32'd0, 32'hFFFF_FFFF, 32'd1000, 1'b1};
        q4 = '{33, 28, 9, 0};
        r4 = '{1, 4, 0, 5};

        req_valid = '0; req_dividend = '0; req_divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_div_valid_in", div_valid_in, 0);
        chk("rst_div_dividend", div_dividend, 0);
        chk("rst_div_divisor", div_divisor, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_quotient", resp_quotient, 0);
        chk("rst_resp_timeout", resp_timeout, 0);
        reset = 1'b1;
        step();

        // Single-requester table: one grant, one divider window, exact result each.
        for (int t = 0; t < 5; t++) begin
            g0 = grant_log.size();
            w0 = vin_windows;
            issue(vt[t].idx, vt[t].a, vt[t].b);
            wait_idle(200);
            chk("tbl_grants", grant_log.size() - g0, 1);
            chk("tbl_windows", vin_windows - w0, 1);
            chk("tbl_idx", resp_log[$], vt[t].idx);
            chk("tbl_quotient", last_q, vt[t].q);
            chk("tbl_remainder", last_r, vt[t].r);
            chk("tbl_overflow", last_ovf, vt[t].ovf);
            chk("tbl_timeout", last_to, 0);
        end

        // All four together after requester 3 was served last: order 0,1,2,3.
        base = resp_log.size();
        issue(0, 100, 3); issue(1, 200, 7); issue(2, 81, 9); issue(3, 5, 10);
        wait_idle(400);
        for (int k = 0; k < 4; k++) begin
            chk("all4_order", resp_log[base + k], k);
            chk("all4_quotient", rq_log[base + k], q4[k]);
            chk("all4_remainder", rr_log[base + k], r4[k]);
        end

        // Requesters 1 and 2 held continuously after 1 is served: grants alternate 2,1,2,1.
        issue(1, 50, 5);
        wait_idle(200);
        sticky = 4'b0110;
        issue(1, 60, 6); issue(2, 70, 7);
        base = grant_log.size();
        n = 0;
        while (grant_log.size() < base + 4 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) fail_bound("alternate");
        sticky = '0;
        req_valid = '0;
        wait_idle(200);
        if (grant_log.size() >= base + 4) begin
            chk("alt_g0", grant_log[base], 2);
            chk("alt_g1", grant_log[base + 1], 1);
            chk("alt_g2", grant_log[base + 2], 2);
            chk("alt_g3", grant_log[base + 3], 1);
        end

        // Hung divider: watchdog answers TO cycles after div_valid_in rises.
        hang = 1'b1;
        issue(0, 99, 3);
        wait_idle(300);
        chk("to_latency", resp_cyc - vin_rise_cyc, TO);
        chk("to_flag", last_to, 1);
        chk("to_quotient", last_q, 0);
        chk("to_remainder", last_r, 0);
        hang = 1'b0;
        issue(1, 50, 7);
        wait_idle(200);
        chk("after_to_idx", resp_log[$], 1);
        chk("after_to_quotient", last_q, 7);
        chk("after_to_remainder", last_r, 1);

        // Asynchronous reset in the middle of a division.
        lat_cfg = 20;
        issue(2, 1000, 10);
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail_bound("reset_busy");
        repeat (3) step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_div_valid_in", div_valid_in, 0);
        chk("arst_busy", busy, 0);
        chk("arst_div_dividend", div_dividend, 0);
        chk("arst_div_divisor", div_divisor, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_resp_quotient", resp_quotient, 0);
        req_valid = '0;
        acc_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        lat_cfg = 3;
        r0 = resp_count;
        repeat (30) step();
        chk("no_resp_after_reset", resp_count, r0);
        base = grant_log.size();
        issue(3, 40, 4); issue(1, 30, 3);
        wait_idle(300);
        if (grant_log.size() >= base + 2) begin
            chk("post_rst_first", grant_log[base], 1);
            chk("post_rst_second", grant_log[base + 1], 3);
        end else begin
            fail_bound("post_rst_grants");
        end

        // Random traffic against the scoreboard.
        tot_g = grant_log.size();
        tot_r = resp_log.size();
        for (int it = 0; it < 40; it++) begin
            lat_cfg = $urandom_range(1, 10);
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                if (mask[i]) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 28));
                    issue(i, ra, rb);
                end
            end
            repeat ($urandom_range(0, 8)) step();
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    issue(i, $urandom, $urandom_range(1, 1000));
                end
            end
            wait_idle(1000);
        end
        chk("rand_resp_count", resp_log.size() - tot_r, grant_log.size() - tot_g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
